// File: rtl/sync_fifo_param_if.sv
// Write/read handshake bundle for sync_fifo_param: the producer/consumer side uses
// the master modport, and the FIFO uses the slave modport.
interface sync_fifo_param_if #(
    parameter int datawidth  = 8,
    parameter int addr_width = 3
);
    logic                  flush;
    logic                  winc;
    logic [datawidth-1:0]  wdata;
    logic                  rinc;
    logic [datawidth-1:0]  rdata;
    logic                  wfull;
    logic                  rempty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [addr_width:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, winc, wdata, rinc,
        input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, winc, wdata, rinc,
        output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost flags, sticky
// overflow/underflow, synchronous flush and selectable first-word-fall-through reads.
module sync_fifo_param #(
    parameter int datawidth     = 8,
    parameter int addr_width    = 3,
    parameter int fwft          = 0,
    parameter int afull_thresh  = (1 << addr_width) - 2,
    parameter int aempty_thresh = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_param_if.slave   bus
);
    localparam logic [addr_width:0]   c_depth   = {1'b1, {addr_width{1'b0}}};
    localparam logic [addr_width:0]   c_afull   = (addr_width+1)'(afull_thresh);
    localparam logic [addr_width:0]   c_aempty  = (addr_width+1)'(aempty_thresh);
    localparam logic [addr_width:0]   c_cnt_one = (addr_width+1)'(1);
    localparam logic [addr_width-1:0] c_ptr_one = (addr_width)'(1);

    logic [datawidth-1:0]  r_mem [1 << addr_width];
    logic [addr_width-1:0] r_wr_ptr;
    logic [addr_width-1:0] r_rd_ptr;
    logic [addr_width:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_clear;
    logic [datawidth-1:0]  w_rdata;

    // A request is taken on the edge where it is high and its flag (sampled from
    // registered state) is low; a refused request only raises its sticky error flag.
    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = bus.winc && !w_full;
    assign w_rd_acc = bus.rinc && !w_empty;
    assign w_clear  = !rst_n || bus.flush;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (bus.winc && w_full)  r_overflow  <= 1'b1;
            if (bus.rinc && w_empty) r_underflow <= 1'b1;
        end
    end

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!w_clear && w_wr_acc) r_mem[r_wr_ptr] <= bus.wdata;
    end

    generate
        if (fwft != 0) begin : g_fwft
            assign w_rdata = r_mem[r_rd_ptr];
        end else begin : g_reg_read
            logic [datawidth-1:0] r_rdata;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else if (!bus.flush && w_rd_acc) begin
                    r_rdata <= r_mem[r_rd_ptr];
                end
            end
            assign w_rdata = r_rdata;
        end
    endgenerate

    assign bus.rdata        = w_rdata;
    assign bus.wfull        = w_full;
    assign bus.rempty       = w_empty;
    assign bus.almost_full  = (r_count >= c_afull);
    assign bus.almost_empty = (r_count <= c_aempty);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-read instance (dut0) checked against a
// queue-based model, and a first-word-fall-through instance (dut1).
module tb_sync_fifo_param;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    sync_fifo_param_if #(.datawidth(8), .addr_width(3)) bus0 ();
    sync_fifo_param_if #(.datawidth(8), .addr_width(3)) bus1 ();

    sync_fifo_param #(.datawidth(8), .addr_width(3), .fwft(0), .afull_thresh(6), .aempty_thresh(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    sync_fifo_param #(.datawidth(8), .addr_width(3), .fwft(1), .afull_thresh(6), .aempty_thresh(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model / scoreboard for dut0 ----------------
    logic [7:0] exp_q[$];
    int         m_count;
    bit         m_ovf;
    bit         m_udf;
    logic [7:0] m_rdata;

    // One clock of stimulus on dut0; the model is advanced with the same rules and
    // the popped expected word lands in m_rdata when the read is accepted.
    task automatic step0(input bit w, input logic [7:0] wd, input bit r, output bit racc);
        bit wacc;
        bus0.winc  = w;
        bus0.wdata = wd;
        bus0.rinc  = r;
        wacc = w && (m_count != 8);
        racc = r && (m_count != 0);
        if (w && m_count == 8) m_ovf = 1'b1;
        if (r && m_count == 0) m_udf = 1'b1;
        if (racc) m_rdata = exp_q.pop_front();
        if (wacc) exp_q.push_back(wd);
        m_count = m_count + int'(wacc) - int'(racc);
        @(posedge clk); #1;
        bus0.winc = 1'b0;
        bus0.rinc = 1'b0;
    endtask

    task automatic flush0();
        bus0.flush = 1'b1;
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        @(posedge clk); #1;
        bus0.flush = 1'b0;
    endtask

    task automatic step1(input bit w, input logic [7:0] wd, input bit r, input bit fl);
        bus1.winc  = w;
        bus1.wdata = wd;
        bus1.rinc  = r;
        bus1.flush = fl;
        @(posedge clk); #1;
        bus1.winc  = 1'b0;
        bus1.rinc  = 1'b0;
        bus1.flush = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus0.winc = 1'b1; bus0.rinc = 1'b1; bus0.wdata = 8'h55; bus0.flush = 1'b0;
        bus1.winc = 1'b1; bus1.rinc = 1'b1; bus1.wdata = 8'h66; bus1.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus0.winc = 1'b0; bus0.rinc = 1'b0;
        bus1.winc = 1'b0; bus1.rinc = 1'b0;
        exp_q.delete();
        m_count = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 8'h00;
        n_tests++; if (bus0.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus0.count); end
        n_tests++; if (bus0.rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %b expected 1", bus0.rempty); end
        n_tests++; if (bus0.wfull !== 1'b0) begin n_fail++; $display("FAIL reset_wfull: got %b expected 0", bus0.wfull); end
        n_tests++; if (bus0.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b expected 1", bus0.almost_empty); end
        n_tests++; if (bus0.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b expected 0", bus0.almost_full); end
        n_tests++; if (bus0.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus0.overflow); end
        n_tests++; if (bus0.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b expected 0", bus0.underflow); end
        n_tests++; if (bus0.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", bus0.rdata); end
        n_tests++; if (bus1.count !== 4'd0 || bus1.rempty !== 1'b1) begin
            n_fail++; $display("FAIL reset_fwft: got count %0d rempty %b expected 0 1", bus1.count, bus1.rempty); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (bus0.count !== 4'd0) begin n_fail++; $display("FAIL reset_release_count: got %0d expected 0", bus0.count); end
    endtask

    task automatic test_fill_overflow();
        bit racc;
        for (int i = 0; i < 8; i++) begin
            step0(1'b1, 8'(i), 1'b0, racc);
            n_tests++; if (bus0.count !== 4'(m_count)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus0.count, m_count); end
            n_tests++; if (bus0.almost_empty !== (m_count <= 1)) begin n_fail++; $display("FAIL fill_aempty[%0d]: got %b expected %b", i, bus0.almost_empty, m_count <= 1); end
            n_tests++; if (bus0.almost_full !== (m_count >= 6)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, bus0.almost_full, m_count >= 6); end
            n_tests++; if (bus0.wfull !== (m_count == 8)) begin n_fail++; $display("FAIL fill_wfull[%0d]: got %b expected %b", i, bus0.wfull, m_count == 8); end
            n_tests++; if (bus0.rempty !== 1'b0) begin n_fail++; $display("FAIL fill_rempty[%0d]: got %b expected 0", i, bus0.rempty); end
        end
        step0(1'b1, 8'hFF, 1'b0, racc);
        n_tests++; if (bus0.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus0.overflow); end
        n_tests++; if (bus0.count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d expected 8", bus0.count); end
    endtask

    task automatic test_drain_underflow();
        bit racc;
        for (int i = 0; i < 8; i++) begin
            step0(1'b0, 8'h00, 1'b1, racc);
            n_tests++; if (!racc || bus0.rdata !== m_rdata) begin n_fail++; $display("FAIL drain_rdata[%0d]: got %h expected %h", i, bus0.rdata, m_rdata); end
            n_tests++; if (bus0.rempty !== (m_count == 0)) begin n_fail++; $display("FAIL drain_rempty[%0d]: got %b expected %b", i, bus0.rempty, m_count == 0); end
        end
        step0(1'b0, 8'h00, 1'b1, racc);
        n_tests++; if (bus0.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_flag: got %b expected 1", bus0.underflow); end
        n_tests++; if (bus0.rdata !== 8'h07) begin n_fail++; $display("FAIL udf_rdata_hold: got %h expected 07", bus0.rdata); end
        n_tests++; if (bus0.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus0.overflow); end
    endtask

    task automatic test_simultaneous();
        bit racc;
        logic [7:0] d;
        flush0();
        n_tests++; if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin
            n_fail++; $display("FAIL sim_flush_flags: got ovf %b udf %b expected 0 0", bus0.overflow, bus0.underflow); end
        n_tests++; if (bus0.rdata !== 8'h07) begin n_fail++; $display("FAIL sim_flush_rdata_hold: got %h expected 07", bus0.rdata); end
        d = 8'h10;
        repeat (4) begin step0(1'b1, d, 1'b0, racc); d++; end
        for (int i = 0; i < 3; i++) begin
            step0(1'b1, d, 1'b1, racc); d++;
            n_tests++; if (bus0.count !== 4'd4) begin n_fail++; $display("FAIL sim_mid_count[%0d]: got %0d expected 4", i, bus0.count); end
            n_tests++; if (bus0.rdata !== m_rdata) begin n_fail++; $display("FAIL sim_mid_rdata[%0d]: got %h expected %h", i, bus0.rdata, m_rdata); end
        end
        repeat (4) begin step0(1'b1, d, 1'b0, racc); d++; end
        step0(1'b1, d, 1'b1, racc); d++;
        n_tests++; if (bus0.count !== 4'd7) begin n_fail++; $display("FAIL sim_full_count: got %0d expected 7", bus0.count); end
        n_tests++; if (bus0.overflow !== 1'b1) begin n_fail++; $display("FAIL sim_full_ovf: got %b expected 1", bus0.overflow); end
        n_tests++; if (bus0.rdata !== m_rdata) begin n_fail++; $display("FAIL sim_full_rdata: got %h expected %h", bus0.rdata, m_rdata); end
        for (int i = 0; i < 7; i++) begin
            step0(1'b0, 8'h00, 1'b1, racc);
            n_tests++; if (bus0.rdata !== m_rdata) begin n_fail++; $display("FAIL sim_drain_rdata[%0d]: got %h expected %h", i, bus0.rdata, m_rdata); end
        end
        n_tests++; if (bus0.underflow !== 1'b0) begin n_fail++; $display("FAIL sim_pre_udf: got %b expected 0", bus0.underflow); end
        step0(1'b1, 8'h99, 1'b1, racc);
        n_tests++; if (bus0.count !== 4'd1) begin n_fail++; $display("FAIL sim_empty_count: got %0d expected 1", bus0.count); end
        n_tests++; if (bus0.underflow !== 1'b1) begin n_fail++; $display("FAIL sim_empty_udf: got %b expected 1", bus0.underflow); end
        step0(1'b0, 8'h00, 1'b1, racc);
        n_tests++; if (bus0.rdata !== 8'h99) begin n_fail++; $display("FAIL sim_empty_rdata: got %h expected 99", bus0.rdata); end
    endtask

    task automatic test_wrap_random();
        bit racc;
        bit w;
        bit r;
        logic [7:0] d;
        int last;
        int n_wr;
        int cyc;
        flush0();
        d = 8'h00; last = -1; n_wr = 0; cyc = 0;
        while (cyc < 40 || (n_wr < 34 && cyc < 80)) begin
            w = (cyc >= 40) ? 1'b1 : ($urandom_range(0, 7) != 0);
            r = (cyc >= 40) ? 1'b1 : ($urandom_range(0, 7) != 0);
            if (w && m_count != 8) begin n_wr++; step0(1'b1, d, r, racc); d++; end
            else step0(w, d, r, racc);
            n_tests++; if (bus0.count !== 4'(m_count)) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", cyc, bus0.count, m_count); end
            if (racc) begin
                n_tests++; if (bus0.rdata !== m_rdata || int'(bus0.rdata) != last + 1) begin
                    n_fail++; $display("FAIL wrap_rdata[%0d]: got %h expected %h", cyc, bus0.rdata, m_rdata); end
                last = int'(m_rdata);
            end
            cyc++;
        end
    endtask

    task automatic test_fwft_flush();
        step1(1'b1, 8'hA5, 1'b0, 1'b0);
        n_tests++; if (bus1.rempty !== 1'b0) begin n_fail++; $display("FAIL fwft_rempty: got %b expected 0", bus1.rempty); end
        n_tests++; if (bus1.rdata !== 8'hA5) begin n_fail++; $display("FAIL fwft_first: got %h expected a5", bus1.rdata); end
        step1(1'b1, 8'h3C, 1'b0, 1'b0);
        n_tests++; if (bus1.rdata !== 8'hA5) begin n_fail++; $display("FAIL fwft_hold: got %h expected a5", bus1.rdata); end
        step1(1'b0, 8'h00, 1'b1, 1'b0);
        n_tests++; if (bus1.rdata !== 8'h3C) begin n_fail++; $display("FAIL fwft_pop: got %h expected 3c", bus1.rdata); end
        n_tests++; if (bus1.count !== 4'd1) begin n_fail++; $display("FAIL fwft_pop_count: got %0d expected 1", bus1.count); end
        step1(1'b0, 8'h00, 1'b1, 1'b0);
        step1(1'b0, 8'h00, 1'b1, 1'b0);
        n_tests++; if (bus1.underflow !== 1'b1) begin n_fail++; $display("FAIL fwft_udf: got %b expected 1", bus1.underflow); end
        step1(1'b1, 8'h77, 1'b0, 1'b1);
        n_tests++; if (bus1.count !== 4'd0 || bus1.rempty !== 1'b1) begin
            n_fail++; $display("FAIL flush_state: got count %0d rempty %b expected 0 1", bus1.count, bus1.rempty); end
        n_tests++; if (bus1.overflow !== 1'b0 || bus1.underflow !== 1'b0) begin
            n_fail++; $display("FAIL flush_flags: got ovf %b udf %b expected 0 0", bus1.overflow, bus1.underflow); end
        step1(1'b0, 8'h00, 1'b0, 1'b0);
        n_tests++; if (bus1.count !== 4'd0) begin n_fail++; $display("FAIL flush_write_ignored: got %0d expected 0", bus1.count); end
        step1(1'b1, 8'h5A, 1'b0, 1'b0);
        n_tests++; if (bus1.rdata !== 8'h5A || bus1.count !== 4'd1) begin
            n_fail++; $display("FAIL flush_reuse: got %h count %0d expected 5a 1", bus1.rdata, bus1.count); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_wrap_random();
        test_fwft_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
